mipsfpga_ahb_tone_sequencer: RTL and testbench

Note scheduler for the MIPSfpga buzzer. The CPU queues notes, each a half-period in microseconds plus a duration in milliseconds. The block plays them back-to-back by driving the buzzer's `numMicros` input, so the CPU no longer has to time each tone in software. It sits between the AHB register decode (write strobes) and the buzzer instance.

---
 rtl/mipsfpga_tone_pkg.sv | 21 ++
 rtl/mipsfpga_tone_fifo.sv | 74 +++++++
 rtl/mipsfpga_ahb_tone_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mipsfpga_ahb_tone_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mipsfpga_tone_pkg.sv
// Shared types for the MIPSfpga buzzer note sequencer: FSM states, the queued
// note record and its field widths.
package mipsfpga_tone_pkg;

    localparam int HALF_US_W = 20;
    localparam int DUR_MS_W  = 12;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        NEXT = 3'd4
    } tone_state_t;

    typedef struct packed {
        logic [HALF_US_W-1:0] half_us;
        logic [DUR_MS_W-1:0]  dur_ms;
    } tone_note_t;

endpackage

// File: rtl/mipsfpga_tone_fifo.sv
// Synchronous note FIFO with occupancy count and a flush that empties it in one
// cycle. A push while full is dropped, even when a pop happens in the same cycle.
module mipsfpga_tone_fifo
    import mipsfpga_tone_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  tone_note_t             wr_data,
    output tone_note_t             rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    tone_note_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Flush wins over both ports so a write in the flush cycle is lost.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/mipsfpga_ahb_tone_sequencer.sv
// Plays queued notes back-to-back on the buzzer's numMicros input.
// Define MIPSFPGA_TONE_GAP_EN to insert GAP_MS of silence after every note.
module mipsfpga_ahb_tone_sequencer
    import mipsfpga_tone_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TICK_CYCLES = 50000,
    parameter int GAP_MS      = 10
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [HALF_US_W-1:0]   wr_half_us,
    input  logic [DUR_MS_W-1:0]    wr_dur_ms,
    input  logic                   flush,
    output logic [31:0]            num_micros,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output tone_state_t            dbg_state
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]       PRESC_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [DUR_MS_W-1:0] MS_ONE    = DUR_MS_W'(1);
    localparam logic [DUR_MS_W-1:0] GAP_TICKS = DUR_MS_W'(GAP_MS);

    tone_state_t         state_q, state_d;
    tone_note_t          note_q, note_d;
    logic [DUR_MS_W-1:0] ms_left_q, ms_left_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [31:0]         num_micros_q, num_micros_d;
    logic                done_q, done_d;

    tone_note_t          fifo_rd;
    tone_note_t          fifo_wr;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                tick;

    assign fifo_wr.half_us = wr_half_us;
    assign fifo_wr.dur_ms  = wr_dur_ms;

    mipsfpga_tone_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (wr_en),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .count   (count),
        .full    (full),
        .empty   (fifo_empty)
    );

    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        state_d      = state_q;
        note_d       = note_q;
        ms_left_d    = ms_left_q;
        presc_d      = presc_q;
        num_micros_d = num_micros_q;
        done_d       = 1'b0;
        fifo_pop     = 1'b0;
        if (flush) begin
            state_d      = IDLE;
            num_micros_d = '0;
            presc_d      = '0;
            ms_left_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    num_micros_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        note_d   = fifo_rd;
                        state_d  = LOAD;
                    end
                end
                LOAD: begin
                    // Zero-duration notes are skipped without touching the output.
                    if (note_q.dur_ms == '0) begin
                        state_d = NEXT;
                    end else begin
                        num_micros_d = {{(32-HALF_US_W){1'b0}}, note_q.half_us};
                        ms_left_d    = note_q.dur_ms;
                        presc_d      = '0;
                        state_d      = PLAY;
                    end
                end
                PLAY: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (ms_left_q == MS_ONE) begin
                            // ms_left is reused as the silence countdown.
                            ms_left_d = GAP_TICKS;
`ifdef MIPSFPGA_TONE_GAP_EN
                            if (GAP_TICKS != '0) begin
                                num_micros_d = '0;
                                state_d      = GAP;
                            end else begin
                                state_d = NEXT;
                            end
`else
                            state_d = NEXT;
`endif
                        end else begin
                            ms_left_d = ms_left_q - MS_ONE;
                        end
                    end
                end
`ifdef MIPSFPGA_TONE_GAP_EN
                GAP: begin
                    num_micros_d = '0;
                    presc_d      = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (ms_left_q == MS_ONE) begin
                            ms_left_d = '0;
                            state_d   = NEXT;
                        end else begin
                            ms_left_d = ms_left_q - MS_ONE;
                        end
                    end
                end
`endif
                NEXT: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        note_d   = fifo_rd;
                        state_d  = LOAD;
                    end else begin
                        num_micros_d = '0;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    num_micros_d = '0;
                    state_d      = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            note_q       <= '0;
            ms_left_q    <= '0;
            presc_q      <= '0;
            num_micros_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            note_q       <= note_d;
            ms_left_q    <= ms_left_d;
            presc_q      <= presc_d;
            num_micros_q <= num_micros_d;
            done_q       <= done_d;
        end
    end

    assign num_micros = num_micros_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mipsfpga_ahb_tone_sequencer.sv
// Bench for the tone sequencer: a per-cycle expected waveform of
// {done, busy, num_micros} is built from each note batch and checked by a monitor.
module tb_mipsfpga_ahb_tone_sequencer;
    import mipsfpga_tone_pkg::*;

    localparam int DEPTH = 4;
    localparam int TICK  = 4;
    localparam int GAPMS = 1;
`ifdef MIPSFPGA_TONE_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif
    localparam int W = 34;

    typedef struct {
        logic [19:0] half_us;
        logic [11:0] dur_ms;
    } note_t;

    logic        clk;
    logic        resetn;
    logic        wr_en;
    logic [19:0] wr_half_us;
    logic [11:0] wr_dur_ms;
    logic        flush;
    logic [31:0] num_micros;
    logic        full;
    logic [2:0]  count;
    logic        busy;
    logic        done;
    tone_state_t dbg_state;

    logic [W-1:0] exp_q[$];
    note_t        batch[$];
    int           n_cmp;
    int           n_err;

    mipsfpga_ahb_tone_sequencer #(
        .DEPTH       (DEPTH),
        .TICK_CYCLES (TICK),
        .GAP_MS      (GAPMS)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_half_us (wr_half_us),
        .wr_dur_ms  (wr_dur_ms),
        .flush      (flush),
        .num_micros (num_micros),
        .full       (full),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one entry per clock cycle, starting with the cycle after the
    // first write edge, derived from the note-scheduling rules.
    task automatic build_expect();
        logic [31:0] cur;
        cur = 32'd0;
        exp_q.push_back({1'b0, 1'b0, 32'd0});
        foreach (batch[i]) begin
            exp_q.push_back({1'b0, 1'b1, cur});
            if (batch[i].dur_ms != 12'd0) begin
                cur = {12'd0, batch[i].half_us};
                for (int c = 0; c < int'(batch[i].dur_ms) * TICK; c++)
                    exp_q.push_back({1'b0, 1'b1, cur});
                if (GAP_ON && GAPMS > 0) begin
                    cur = 32'd0;
                    for (int c = 0; c < GAPMS * TICK; c++)
                        exp_q.push_back({1'b0, 1'b1, cur});
                end
            end
            exp_q.push_back({1'b0, 1'b1, cur});
        end
        exp_q.push_back({1'b1, 1'b0, 32'd0});
        exp_q.push_back({1'b0, 1'b0, 32'd0});
    endtask

    // Driver: queue the expectation, write the batch on consecutive cycles, then
    // wait (bounded) for the monitor to drain it.
    task automatic run_batch();
        int budget;
        @(negedge clk);
        build_expect();
        budget = exp_q.size() + 20;
        foreach (batch[i]) begin
            wr_en      = 1'b1;
            wr_half_us = batch[i].half_us;
            wr_dur_ms  = batch[i].dur_ms;
            @(negedge clk);
        end
        wr_en = 1'b0;
        for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("batch_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        batch.delete();
    endtask

    task automatic add_note(input logic [19:0] h, input logic [11:0] d);
        note_t n;
        n.half_us = h;
        n.dur_ms  = d;
        batch.push_back(n);
    endtask

    // Monitor: one scoreboard comparison per cycle while expectations are pending.
    initial begin
        logic [W-1:0] req;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                req = exp_q.pop_front();
                check("wave{done,busy,num}", 64'({done, busy, num_micros}), 64'(req));
            end
        end
    end

    initial begin
        bit quiet;
        n_cmp      = 0;
        n_err      = 0;
        resetn     = 1'b0;
        wr_en      = 1'b0;
        wr_half_us = '0;
        wr_dur_ms  = '0;
        flush      = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_num_micros", 64'(num_micros), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // Directed batches
        add_note(20'd250, 12'd3);
        run_batch();
        add_note(20'd100, 12'd1);
        add_note(20'd0, 12'd2);
        add_note(20'd300, 12'd1);
        run_batch();
        add_note(20'd500, 12'd0);
        add_note(20'd200, 12'd1);
        run_batch();
        add_note(20'd100, 12'd1);
        add_note(20'd200, 12'd1);
        run_batch();

        // Random batches
        for (int b = 0; b < 25; b++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                logic [19:0] h;
                logic [11:0] d;
                h = ($urandom_range(0, 4) == 0) ? 20'd0 : 20'($urandom_range(1, 20'hFFFFF));
                d = 12'($urandom_range(0, 3));
                add_note(h, d);
            end
            run_batch();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Fill the FIFO behind a long note, then flush with a simultaneous write
        @(negedge clk);
        wr_en = 1'b1; wr_half_us = 20'd100; wr_dur_ms = 12'd20;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_half_us = 20'(11 + i); wr_dur_ms = 12'd1;
            @(negedge clk);
            check("fill_count", 64'(count), 64'(i + 1));
            check("fill_full", 64'(full), 64'(i == 3));
        end
        wr_half_us = 20'd999;
        @(negedge clk);
        wr_en = 1'b0;
        check("drop_count", 64'(count), 64'd4);
        check("drop_full", 64'(full), 64'd1);
        check("mid_note_num", 64'(num_micros), 64'd100);
        flush = 1'b1; wr_en = 1'b1; wr_half_us = 20'd777; wr_dur_ms = 12'd2;
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0;
        check("flush_num", 64'(num_micros), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_state_idle", 64'(dbg_state), 64'(IDLE));
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy || done || num_micros != 32'd0 || count != 3'd0) quiet = 1'b0;
        end
        check("post_flush_quiet", 64'(quiet), 64'd1);

        // Asynchronous reset in the middle of a note
        wr_en = 1'b1; wr_half_us = 20'd300; wr_dur_ms = 12'd5;
        @(negedge clk);
        wr_half_us = 20'd400;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_num", 64'(num_micros), 64'd300);
        check("pre_reset_count", 64'(count), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_num", 64'(num_micros), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_full", 64'(full), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
